// File: rtl/wired_fetch_buffer.sv
// rtl/wired_fetch_buffer.sv - instruction buffer between fetch and decode
// Compacts 2-slot fetch packets into a circular queue and presents up to 2 instructions per cycle.
module wired_fetch_buffer #(
  parameter int DEPTH  = 8,
  parameter int PRED_W = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      f_valid_i,
  output logic                      f_ready_o,
  input  logic [31:0]               f_pc_i,
  input  logic [1:0]                f_mask_i,
  input  logic [63:0]               f_inst_i,
  input  logic [2*PRED_W-1:0]       f_pred_i,
  output logic [1:0]                d_valid_o,
  input  logic                      d_ready_i,
  output logic [63:0]               d_pc_o,
  output logic [63:0]               d_inst_o,
  output logic [2*PRED_W-1:0]       d_pred_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       inst_q [DEPTH];
  logic [PRED_W-1:0] pred_q [DEPTH];

  logic              enq;
  logic              wr0_en, wr1_en;
  logic [31:0]       wr0_pc, wr1_pc;
  logic [31:0]       wr0_inst;
  logic [PRED_W-1:0] wr0_pred;
  logic [AW-1:0]     wptr_p1, rptr_p1;
  logic [CW-1:0]     n_enq, n_deq;
  logic              unused_pc_lsbs;

  assign unused_pc_lsbs = ^f_pc_i[2:0];

  // Ready and valid come only from registered count so there is no ready->valid loop.
  assign f_ready_o    = (count_q <= READY_MAX) && !flush_i;
  assign d_valid_o[0] = (count_q >= CW'(1)) && !flush_i;
  assign d_valid_o[1] = (count_q >= CW'(2)) && !flush_i;
  assign count_o      = count_q;

  assign wptr_p1 = wptr_q + AW'(1);
  assign rptr_p1 = rptr_q + AW'(1);

  assign d_pc_o   = {pc_q[rptr_p1],   pc_q[rptr_q]};
  assign d_inst_o = {inst_q[rptr_p1], inst_q[rptr_q]};
  assign d_pred_o = {pred_q[rptr_p1], pred_q[rptr_q]};

  always_comb begin
    enq      = f_valid_i && f_ready_o;
    wr0_en   = enq && (|f_mask_i);
    wr1_en   = enq && (&f_mask_i);
    // A lone slot 1 is compacted into the first free entry.
    wr0_pc   = {f_pc_i[31:3], (f_mask_i == 2'b10), 2'b00};
    wr1_pc   = {f_pc_i[31:3], 1'b1, 2'b00};
    wr0_inst = (f_mask_i == 2'b10) ? f_inst_i[63:32] : f_inst_i[31:0];
    wr0_pred = (f_mask_i == 2'b10) ? f_pred_i[2*PRED_W-1:PRED_W] : f_pred_i[PRED_W-1:0];
    n_enq    = CW'(wr0_en) + CW'(wr1_en);
    n_deq    = d_ready_i ? (CW'(d_valid_o[0]) + CW'(d_valid_o[1])) : '0;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + AW'(n_enq);
      rptr_d  = rptr_q + AW'(n_deq);
      count_d = count_q + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) begin
      pc_q[wptr_q]   <= wr0_pc;
      inst_q[wptr_q] <= wr0_inst;
      pred_q[wptr_q] <= wr0_pred;
    end
    if (wr1_en) begin
      pc_q[wptr_p1]   <= wr1_pc;
      inst_q[wptr_p1] <= f_inst_i[63:32];
      pred_q[wptr_p1] <= f_pred_i[2*PRED_W-1:PRED_W];
    end
  end

endmodule

// File: tb/tb_wired_fetch_buffer.sv
// tb/tb_wired_fetch_buffer.sv - directed and scoreboarded checks for wired_fetch_buffer
module tb_wired_fetch_buffer;

  localparam int DEPTH  = 8;
  localparam int PRED_W = 48;

  logic                clk;
  logic                rst_n;
  logic                flush_i;
  logic                f_valid_i;
  logic                f_ready_o;
  logic [31:0]         f_pc_i;
  logic [1:0]          f_mask_i;
  logic [63:0]         f_inst_i;
  logic [2*PRED_W-1:0] f_pred_i;
  logic [1:0]          d_valid_o;
  logic                d_ready_i;
  logic [63:0]         d_pc_o;
  logic [63:0]         d_inst_o;
  logic [2*PRED_W-1:0] d_pred_o;
  logic [3:0]          count_o;

  int checks = 0;
  int errors = 0;

  wired_fetch_buffer #(.DEPTH(DEPTH), .PRED_W(PRED_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .f_valid_i(f_valid_i), .f_ready_o(f_ready_o), .f_pc_i(f_pc_i),
    .f_mask_i(f_mask_i), .f_inst_i(f_inst_i), .f_pred_i(f_pred_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_pc_o(d_pc_o),
    .d_inst_o(d_inst_o), .d_pred_o(d_pred_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] qpc[$];
  logic [31:0] qinst[$];
  logic [31:0] pc_base;
  logic [31:0] i0, i1;
  logic [1:0]  exp_dv;
  logic        exp_rdy;
  int          accepted;
  int          ncyc;
  int          npop;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; f_valid_i = 1'b0; f_pc_i = '0; f_mask_i = '0;
    f_inst_i = '0; f_pred_i = '0; d_ready_i = 1'b0;
    cyc(); cyc();
    chk("rst_count", count_o, 0);
    chk("rst_dvalid", d_valid_o, 2'b00);
    chk("rst_fready", f_ready_o, 1'b1);
    rst_n = 1'b1;
    cyc();

    // 1: full packet appears one cycle later
    f_valid_i = 1'b1; f_pc_i = 32'h1c000000; f_mask_i = 2'b11;
    f_inst_i = {32'hBBBB0001, 32'hAAAA0000};
    f_pred_i = {48'h0000BEEF0001, 48'h0000CAFE0000};
    cyc();
    f_valid_i = 1'b0; #1;
    chk("t1_dvalid", d_valid_o, 2'b11);
    chk("t1_dpc", d_pc_o, {32'h1c000004, 32'h1c000000});
    chk("t1_dinst", d_inst_o, {32'hBBBB0001, 32'hAAAA0000});
    chk("t1_dpred", d_pred_o, {48'h0000BEEF0001, 48'h0000CAFE0000});
    chk("t1_count", count_o, 2);
    d_ready_i = 1'b1; cyc(); d_ready_i = 1'b0; #1;
    chk("t1_drain", count_o, 0);

    // 2: single-slot packets compact
    f_valid_i = 1'b1; f_pc_i = 32'h1c000008; f_mask_i = 2'b10;
    f_inst_i = {32'hCCCC0000, 32'hDEAD0000};
    cyc();
    chk("t2_dvalid1", d_valid_o, 2'b01);
    f_pc_i = 32'h1c000010; f_mask_i = 2'b01; f_inst_i = {32'hDEAD0001, 32'hDDDD0000};
    cyc();
    f_valid_i = 1'b0; #1;
    chk("t2_dpc", d_pc_o, {32'h1c000010, 32'h1c00000c});
    chk("t2_dinst", d_inst_o, {32'hDDDD0000, 32'hCCCC0000});
    chk("t2_count", count_o, 2);
    d_ready_i = 1'b1; cyc(); d_ready_i = 1'b0;
    f_valid_i = 1'b1; f_pc_i = 32'h1c000020; f_mask_i = 2'b01; f_inst_i = {32'h0, 32'hEEEE0000};
    cyc();
    f_valid_i = 1'b0; #1;
    chk("t2_one", count_o, 1);

    // 4: simultaneous enq of 2 and deq of 1
    f_valid_i = 1'b1; f_pc_i = 32'h1c000028; f_mask_i = 2'b11;
    f_inst_i = {32'h2C2C0000, 32'h28280000}; d_ready_i = 1'b1; #1;
    chk("t4_pre_dvalid", d_valid_o, 2'b01);
    chk("t4_pre_pc", d_pc_o[31:0], 32'h1c000020);
    cyc();
    f_valid_i = 1'b0; d_ready_i = 1'b0; #1;
    chk("t4_count", count_o, 2);
    chk("t4_dpc", d_pc_o, {32'h1c00002c, 32'h1c000028});
    f_valid_i = 1'b1; f_pc_i = 32'h1c000030; f_mask_i = 2'b01; d_ready_i = 1'b1;
    cyc();
    f_valid_i = 1'b0; d_ready_i = 1'b0; #1;
    chk("t4_count1", count_o, 1);
    chk("t4_pc30", d_pc_o[31:0], 32'h1c000030);

    // 3: fill until ready drops at count 7
    f_valid_i = 1'b1; f_mask_i = 2'b11;
    f_pc_i = 32'h1c000100; cyc(); chk("t3_c3", count_o, 3);
    f_pc_i = 32'h1c000108; cyc(); chk("t3_c5", count_o, 5);
    chk("t3_rdy5", f_ready_o, 1'b1);
    f_pc_i = 32'h1c000110; cyc(); chk("t3_c7", count_o, 7);
    chk("t3_rdy7", f_ready_o, 1'b0);
    f_pc_i = 32'h1c000118; cyc(); chk("t3_hold", count_o, 7);
    d_ready_i = 1'b1; cyc(); d_ready_i = 1'b0;
    chk("t3_c5b", count_o, 5);
    chk("t3_rdy_back", f_ready_o, 1'b1);
    f_valid_i = 1'b0; #1;
    chk("t3_dpc", d_pc_o, {32'h1c000108, 32'h1c000104});

    // 6: flush with a packet offered
    flush_i = 1'b1; f_valid_i = 1'b1; f_pc_i = 32'h1c000200; f_mask_i = 2'b11; d_ready_i = 1'b1; #1;
    chk("t6_fready", f_ready_o, 1'b0);
    chk("t6_dvalid", d_valid_o, 2'b00);
    cyc();
    flush_i = 1'b0; f_valid_i = 1'b0; d_ready_i = 1'b0; #1;
    chk("t6_count", count_o, 0);
    chk("t6_dvalid_after", d_valid_o, 2'b00);
    chk("t6_fready_after", f_ready_o, 1'b1);

    // 5: random traffic against a queue model
    pc_base = 32'h1c001000; accepted = 0; ncyc = 0;
    while (accepted < 100 && ncyc < 3000) begin
      f_valid_i = ($urandom_range(0, 3) != 0);
      f_mask_i  = 2'($urandom);
      f_pc_i    = pc_base;
      i0 = $urandom; i1 = $urandom;
      f_inst_i  = {i1, i0};
      f_pred_i  = {16'h0, i1, 16'h0, i0};
      d_ready_i = ($urandom_range(0, 1) != 0);
      #1;
      exp_rdy = (qpc.size() <= DEPTH - 2);
      exp_dv  = (qpc.size() >= 2) ? 2'b11 : (qpc.size() == 1) ? 2'b01 : 2'b00;
      chk("r_fready", f_ready_o, exp_rdy);
      chk("r_count", count_o, qpc.size());
      chk("r_dvalid", d_valid_o, exp_dv);
      if (qpc.size() >= 1) begin
        chk("r_pc0", d_pc_o[31:0], qpc[0]);
        chk("r_inst0", d_inst_o[31:0], qinst[0]);
        chk("r_pred0", d_pred_o[PRED_W-1:0], {16'h0, qinst[0]});
      end
      if (qpc.size() >= 2) begin
        chk("r_pc1", d_pc_o[63:32], qpc[1]);
        chk("r_inst1", d_inst_o[63:32], qinst[1]);
      end
      npop = d_ready_i ? ((qpc.size() >= 2) ? 2 : qpc.size()) : 0;
      @(posedge clk);
      for (int k = 0; k < npop; k++) begin
        void'(qpc.pop_front());
        void'(qinst.pop_front());
      end
      if (f_valid_i && exp_rdy) begin
        if (f_mask_i[0]) begin qpc.push_back({pc_base[31:3], 3'b000}); qinst.push_back(i0); end
        if (f_mask_i[1]) begin qpc.push_back({pc_base[31:3], 3'b100}); qinst.push_back(i1); end
        accepted++;
        pc_base = pc_base + 32'd8;
      end
      #1;
      ncyc++;
    end
    chk("r_accepted", accepted, 100);

    // 6b: asynchronous reset mid-stream
    d_ready_i = 1'b0; f_valid_i = 1'b1; f_mask_i = 2'b11; f_pc_i = 32'h1c002000;
    cyc(); cyc();
    #2 rst_n = 1'b0; #1;
    chk("rst_mid_count", count_o, 0);
    chk("rst_mid_dvalid", d_valid_o, 2'b00);
    chk("rst_mid_fready", f_ready_o, 1'b1);
    f_valid_i = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_mid_after", count_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
